// File: rtl/credit_if_else_raw_reg.sv
// Credit register responder for the credit_ifElseRaw extern.
// Holds DEPTH 16-bit credit entries. Each request performs one predicated
// read-modify-write and the updated value is returned two cycles after the
// request is sampled. A post-reset sweep loads INIT_VAL into every entry.
module credit_if_else_raw_reg #(
  parameter int unsigned DEPTH    = 128,
  parameter logic [15:0] INIT_VAL = 16'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [15:0] req_bits_index,
  input  logic [15:0] req_bits_data_1,
  input  logic [7:0]  req_bits_opCode_1,
  input  logic [15:0] req_bits_data_0,
  input  logic [7:0]  req_bits_opCode_0,
  input  logic        req_bits_predicate,
  output logic        resp_valid,
  output logic [15:0] resp_bits_new_val,
  output logic        init_done,
  output logic [15:0] err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [7:0] {
    OP_READ  = 8'd0,
    OP_WRITE = 8'd1,
    OP_ADD   = 8'd2,
    OP_SUB   = 8'd3
  } op_e;

  typedef enum logic {
    ST_SWEEP,
    ST_DONE
  } state_e;

  state_e          state;
  state_e          state_nx;
  logic [CW-1:0]   sweep_cnt;
  logic            sweep_we;

  // Storage: synchronous-read RAM, one read and one write port
  logic [15:0]     mem [DEPTH];
  logic [15:0]     rd_data;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [15:0]     mem_wdata;

  // Request decode
  logic [7:0]      sel_op;
  logic [15:0]     sel_d;
  logic            req_zero;
  logic            req_badop;

  // Stage A: sampled request
  logic            a_valid;
  logic [AW-1:0]   a_addr;
  logic            a_zero;
  logic            a_badop;
  logic [7:0]      a_op;
  logic [15:0]     a_d;

  // Stage B: array data available, compute
  logic            b_valid;
  logic [AW-1:0]   b_addr;
  logic            b_zero;
  logic            b_badop;
  logic [7:0]      b_op;
  logic [15:0]     b_d;
  logic [15:0]     old_val;
  logic [15:0]     new_val;
  logic            b_we;

  // Stage C: registered response, also the forwarding source
  logic [AW-1:0]   c_addr;
  logic            c_fwd;

  // Init-sweep state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_SWEEP;
    else        state <= state_nx;
  end

  // Sweep finishes one cycle after the last entry has been written
  always_comb begin
    state_nx = state;
    sweep_we = 1'b0;
    if (state == ST_SWEEP) begin
      if (sweep_cnt == CW'(DEPTH)) state_nx = ST_DONE;
      else                         sweep_we = 1'b1;
    end
  end

  assign init_done = (state == ST_DONE);

  // Sweep address counter, restarts from 0 on every reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        sweep_cnt <= '0;
    else if (sweep_we) sweep_cnt <= sweep_cnt + CW'(1);
  end

  // Predicate selects the operand pair; flag the error classes up front
  always_comb begin
    sel_op    = req_bits_predicate ? req_bits_opCode_1 : req_bits_opCode_0;
    sel_d     = req_bits_predicate ? req_bits_data_1   : req_bits_data_0;
    req_zero  = ({16'd0, req_bits_index} >= DEPTH) || !init_done;
    req_badop = (sel_op > OP_SUB);
  end

  // Stage A register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_zero  <= 1'b0;
      a_badop <= 1'b0;
      a_op    <= '0;
      a_d     <= '0;
    end else begin
      a_valid <= req_valid;
      a_addr  <= req_bits_index[AW-1:0];
      a_zero  <= req_zero;
      a_badop <= req_badop;
      a_op    <= sel_op;
      a_d     <= sel_d;
    end
  end

  // Write port is owned by the sweep until init completes; requests
  // accepted before then never write, so there is no contention
  always_comb begin
    mem_we    = sweep_we | (b_valid & b_we);
    mem_waddr = sweep_we ? sweep_cnt[AW-1:0] : b_addr;
    mem_wdata = sweep_we ? INIT_VAL : new_val;
  end

  // RAM: write and registered read
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rd_data <= mem[a_addr];
  end

  // Stage B register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_valid <= 1'b0;
      b_addr  <= '0;
      b_zero  <= 1'b0;
      b_badop <= 1'b0;
      b_op    <= '0;
      b_d     <= '0;
    end else begin
      b_valid <= a_valid;
      b_addr  <= a_addr;
      b_zero  <= a_zero;
      b_badop <= a_badop;
      b_op    <= a_op;
      b_d     <= a_d;
    end
  end

  // Read-modify-write. The only write the RAM read can miss is the one that
  // landed on the same edge as the read, which is the previous request now
  // held in stage C; its value is always the current entry contents.
  always_comb begin
    old_val = (c_fwd && (c_addr == b_addr)) ? resp_bits_new_val : rd_data;
    new_val = old_val;
    b_we    = 1'b0;
    if (b_zero) begin
      new_val = '0;
    end else if (!b_badop) begin
      case (b_op)
        OP_WRITE: begin
          new_val = b_d;
          b_we    = 1'b1;
        end
        OP_ADD: begin
          new_val = old_val + b_d;
          b_we    = 1'b1;
        end
        OP_SUB: begin
          new_val = (old_val >= b_d) ? (old_val - b_d) : '0;
          b_we    = 1'b1;
        end
        default: new_val = old_val;
      endcase
    end
  end

  // Stage C: response, forwarding tag and saturating error count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid        <= 1'b0;
      resp_bits_new_val <= '0;
      c_addr            <= '0;
      c_fwd             <= 1'b0;
      err_count         <= '0;
    end else begin
      resp_valid <= b_valid;
      c_fwd      <= b_valid && !b_zero;
      c_addr     <= b_addr;
      if (b_valid) resp_bits_new_val <= new_val;
      if (b_valid && (b_zero || b_badop) && (err_count != '1))
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_credit_if_else_raw_reg.sv
// Bench for credit_if_else_raw_reg: directed vector table, reset/flight
// sequences and randomized traffic against an array-based reference model.
module tb_credit_if_else_raw_reg;

  localparam int unsigned DEPTH    = 128;
  localparam logic [15:0] INIT_VAL = 16'h0000;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_bits_index;
  logic [15:0] req_bits_data_1;
  logic [7:0]  req_bits_opCode_1;
  logic [15:0] req_bits_data_0;
  logic [7:0]  req_bits_opCode_0;
  logic        req_bits_predicate;
  logic        resp_valid;
  logic [15:0] resp_bits_new_val;
  logic        init_done;
  logic [15:0] err_count;

  credit_if_else_raw_reg #(.DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_bits_index     (req_bits_index),
    .req_bits_data_1    (req_bits_data_1),
    .req_bits_opCode_1  (req_bits_opCode_1),
    .req_bits_data_0    (req_bits_data_0),
    .req_bits_opCode_0  (req_bits_opCode_0),
    .req_bits_predicate (req_bits_predicate),
    .resp_valid         (resp_valid),
    .resp_bits_new_val  (resp_bits_new_val),
    .init_done          (init_done),
    .err_count          (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  typedef struct {
    logic [15:0] idx;
    bit          pred;
    logic [7:0]  op1;
    logic [15:0] d1;
    logic [7:0]  op0;
    logic [15:0] d0;
    logic [15:0] expv;
  } vec_t;

  exp_t        q[$];
  int          total;
  int          bad;
  int          cyc;
  int          since_rel;
  int          mdl[DEPTH];
  int          mdl_err;
  vec_t        tbl[18];

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: entries are plain ints, ops applied in request order
  function automatic int model_req(input int idx, input bit pred,
                                   input int op1, input int d1,
                                   input int op0, input int d0);
    int op;
    int d;
    int old;
    op = pred ? op1 : op0;
    d  = pred ? d1 : d0;
    if (since_rel < int'(DEPTH) + 1 || idx >= int'(DEPTH)) begin
      mdl_err = (mdl_err >= 65535) ? 65535 : mdl_err + 1;
      return 0;
    end
    old = mdl[idx];
    if (op == 1)      mdl[idx] = d;
    else if (op == 2) mdl[idx] = (old + d) % 65536;
    else if (op == 3) mdl[idx] = (old >= d) ? old - d : 0;
    else if (op != 0) mdl_err = (mdl_err >= 65535) ? 65535 : mdl_err + 1;
    return mdl[idx];
  endfunction

  // Advance one clock and check everything observable in that cycle
  task automatic step();
    bit exp_v;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (reset) since_rel++;
    exp_v = (q.size() > 0) && (q[0].due == cyc);
    check("resp_valid", resp_valid, exp_v);
    if (exp_v) begin
      check("resp_new_val", resp_bits_new_val, q[0].val);
      void'(q.pop_front());
    end
    check("init_done", init_done, (reset && since_rel >= int'(DEPTH) + 1));
  endtask

  task automatic issue(input bit v, input logic [15:0] idx, input bit pred,
                       input logic [7:0] op1, input logic [15:0] d1,
                       input logic [7:0] op0, input logic [15:0] d0,
                       input bit use_exp, input logic [15:0] expv);
    int m;
    req_valid          = v;
    req_bits_index     = idx;
    req_bits_predicate = pred;
    req_bits_opCode_1  = op1;
    req_bits_data_1    = d1;
    req_bits_opCode_0  = op0;
    req_bits_data_0    = d0;
    if (v) begin
      m = model_req(int'(idx), pred, int'(op1), int'(d1), int'(op0), int'(d0));
      q.push_back('{due: cyc + 3, val: use_exp ? expv : 16'(m)});
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 16'd0, 1'b0, 8'd0, 16'd0, 8'd0, 16'd0, 1'b0, 16'd0);
  endtask

  // Assert reset for a few cycles; anything in flight is dropped
  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 1'b0;
    q.delete();
    since_rel = 0;
    mdl_err   = 0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = int'(INIT_VAL);
    for (int i = 0; i < 3; i++) step();
    check("err_count_in_reset", err_count, 0);
    reset = 1'b1;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 400 && !init_done; i++) step();
    check("init_latency", since_rel, int'(DEPTH) + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0; since_rel = 0; mdl_err = 0;
    reset = 1'b0;
    req_valid = 1'b0; req_bits_index = '0; req_bits_predicate = 1'b0;
    req_bits_opCode_1 = '0; req_bits_data_1 = '0;
    req_bits_opCode_0 = '0; req_bits_data_0 = '0;

    #2;
    check("reset_resp_valid", resp_valid, 0);
    check("reset_new_val", resp_bits_new_val, 0);
    check("reset_init_done", init_done, 0);
    check("reset_err_count", err_count, 0);

    do_reset();
    // Request during the sweep: zero response, counted as error
    issue(1'b1, 16'd4, 1'b0, 8'd1, 16'd99, 8'd1, 16'd99, 1'b1, 16'd0);
    wait_init();

    //          idx     pred  op1    d1        op0    d0       expected
    tbl[0]  = '{16'd5,   1'b0, 8'd1, 16'h1234, 8'd0, 16'd0,    16'd0};
    tbl[1]  = '{16'd3,   1'b1, 8'd1, 16'd100,  8'd2, 16'd7,    16'd100};
    tbl[2]  = '{16'd3,   1'b0, 8'd1, 16'hBEEF, 8'd2, 16'd20,   16'd120};
    tbl[3]  = '{16'd3,   1'b1, 8'd3, 16'd20,   8'd1, 16'd5,    16'd100};
    tbl[4]  = '{16'd9,   1'b1, 8'd1, 16'd10,   8'd2, 16'd1,    16'd10};
    tbl[5]  = '{16'd9,   1'b0, 8'd1, 16'd1,    8'd3, 16'd25,   16'd0};
    tbl[6]  = '{16'd11,  1'b1, 8'd1, 16'hFFF0, 8'd0, 16'd0,    16'hFFF0};
    tbl[7]  = '{16'd11,  1'b1, 8'd2, 16'h0020, 8'd1, 16'd3,    16'h0010};
    tbl[8]  = '{16'd7,   1'b0, 8'd1, 16'hAAAA, 8'd2, 16'd1,    16'd1};
    tbl[9]  = '{16'd7,   1'b0, 8'd1, 16'hAAAA, 8'd2, 16'd1,    16'd2};
    tbl[10] = '{16'd7,   1'b0, 8'd1, 16'hAAAA, 8'd2, 16'd1,    16'd3};
    tbl[11] = '{16'd7,   1'b0, 8'd1, 16'hAAAA, 8'd2, 16'd1,    16'd4};
    tbl[12] = '{16'd7,   1'b1, 8'd0, 16'd0,    8'd1, 16'd9,    16'd4};
    tbl[13] = '{16'd200, 1'b0, 8'd1, 16'd0,    8'd1, 16'd55,   16'd0};
    tbl[14] = '{16'd20,  1'b1, 8'd9, 16'd77,   8'd1, 16'd77,   16'd0};
    tbl[15] = '{16'd20,  1'b0, 8'd1, 16'd1,    8'd0, 16'd0,    16'd0};
    tbl[16] = '{16'd72,  1'b0, 8'd1, 16'd1,    8'd0, 16'd0,    16'd0};
    tbl[17] = '{16'd4,   1'b0, 8'd1, 16'd1,    8'd0, 16'd0,    16'd0};

    foreach (tbl[i])
      issue(1'b1, tbl[i].idx, tbl[i].pred, tbl[i].op1, tbl[i].d1,
            tbl[i].op0, tbl[i].d0, 1'b1, tbl[i].expv);
    idle(3);
    check("err_count_directed", err_count, 3);

    // Randomized traffic, small index window to provoke hazards
    for (int n = 0; n < 500; n++) begin
      logic [15:0] idx;
      logic [7:0]  o1;
      logic [7:0]  o0;
      bit          v;
      v   = ($urandom % 4) != 0;
      idx = (($urandom % 16) == 0) ? 16'(128 + $urandom % 300) : 16'($urandom % 8);
      o1  = (($urandom % 12) == 0) ? 8'(4 + $urandom % 252) : 8'($urandom % 4);
      o0  = (($urandom % 12) == 0) ? 8'(4 + $urandom % 252) : 8'($urandom % 4);
      issue(v, idx, 1'($urandom), o1, 16'($urandom), o0, 16'($urandom), 1'b0, 16'd0);
    end
    idle(3);
    check("err_count_random", err_count, mdl_err);

    // Reset with two requests in flight
    issue(1'b1, 16'd30, 1'b1, 8'd1, 16'd55, 8'd0, 16'd0, 1'b1, 16'd55);
    idle(3);
    issue(1'b1, 16'd31, 1'b1, 8'd1, 16'd77, 8'd0, 16'd0, 1'b1, 16'd77);
    issue(1'b1, 16'd30, 1'b0, 8'd0, 16'd0,  8'd2, 16'd1, 1'b1, 16'd56);
    do_reset();
    wait_init();
    issue(1'b1, 16'd30, 1'b0, 8'd1, 16'd1, 8'd0, 16'd0, 1'b1, INIT_VAL);
    issue(1'b1, 16'd31, 1'b1, 8'd0, 16'd0, 8'd1, 16'd1, 1'b1, INIT_VAL);
    issue(1'b1, 16'd7,  1'b1, 8'd0, 16'd0, 8'd1, 16'd1, 1'b1, INIT_VAL);
    idle(3);
    check("err_count_after_reset", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
